// File: rtl/move_queue_ctrl_pkg.sv
// Shared move definitions: direction codes and their width.
// Also imported by the game loop, so the codes here are the system-wide encoding.
package move_pkg;

    localparam int unsigned DIR_W = 2;

    typedef enum logic [DIR_W-1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

endpackage

// File: rtl/move_queue_ctrl_if.sv
// Move handshake between the input controller (master) and the game loop (slave).
interface move_queue_ctrl_if;

    logic                       move_valid;
    logic [move_pkg::DIR_W-1:0] move_dir;
    logic                       move_ready;

    modport master (output move_valid, output move_dir, input move_ready);
    modport slave  (input move_valid, input move_dir, output move_ready);

endinterface

// File: rtl/move_queue_ctrl_button_debounce.sv
// One button: 2-flop synchronizer, counting debouncer, registered press pulse.
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_press
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_stable;
    logic          r_stable_d;
    logic [CW-1:0] r_cnt;
    logic          r_press;

    // Synchronize, debounce, and pulse on a stable rising level.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_stable   <= 1'b0;
            r_stable_d <= 1'b0;
            r_cnt      <= '0;
            r_press    <= 1'b0;
        end else begin
            r_sync1    <= i_btn;
            r_sync2    <= r_sync1;
            r_stable_d <= r_stable;
            r_press    <= r_stable & ~r_stable_d;
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DEBOUNCE_CYCLES)) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/move_queue_ctrl.sv
// Button-to-move controller: four debounced buttons, fixed-priority arbiter,
// small register FIFO of moves, and a saturating drop counter.
module move_queue_ctrl
    import move_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned FIFO_DEPTH      = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        up,
    input  logic                        down,
    input  logic                        left,
    input  logic                        right,
    move_queue_ctrl_if.master           mq,
    output logic [$clog2(FIFO_DEPTH):0] pending,
    output logic [7:0]                  drop_count
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic [3:0]       w_raw;
    logic [3:0]       w_press;
    logic [DIR_W-1:0] w_sel;
    logic [2:0]       w_nev;
    logic [2:0]       w_drops;
    logic [8:0]       w_drop_sum;
    logic             w_any;
    logic             w_full;
    logic             w_deq;
    logic             w_enq;

    logic [DIR_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic [7:0]       r_drop;

    // Bit index equals the direction code.
    assign w_raw = {right, left, down, up};

    for (genvar g = 0; g < 4; g++) begin : g_btn
        button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
            .clk     (clk),
            .rst     (rst),
            .i_btn   (w_raw[g]),
            .o_press (w_press[g])
        );
    end

    // Arbitrate same-cycle presses and count everything that is discarded.
    always_comb begin
        w_sel = DIR_UP;
        if (w_press[0])      w_sel = DIR_UP;
        else if (w_press[1]) w_sel = DIR_DOWN;
        else if (w_press[2]) w_sel = DIR_LEFT;
        else if (w_press[3]) w_sel = DIR_RIGHT;
        w_any   = |w_press;
        w_nev   = {2'b00, w_press[0]} + {2'b00, w_press[1]}
                + {2'b00, w_press[2]} + {2'b00, w_press[3]};
        w_full  = (r_count == (AW + 1)'(FIFO_DEPTH));
        w_deq   = mq.move_valid && mq.move_ready;
        w_enq   = w_any && (!w_full || w_deq);
        w_drops = (w_any ? w_nev - 3'd1 : 3'd0)
                + {2'b00, (w_any && w_full && !w_deq)};
        w_drop_sum = {1'b0, r_drop} + {6'b0, w_drops};
    end

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) begin
                r_mem[r_wptr] <= w_sel;
                r_wptr        <= r_wptr + AW'(1);
            end
            if (w_deq) r_rptr <= r_rptr + AW'(1);
            if (w_enq && !w_deq)      r_count <= r_count + (AW + 1)'(1);
            else if (!w_enq && w_deq) r_count <= r_count - (AW + 1)'(1);
        end
    end

    // Saturating drop counter.
    always_ff @(posedge clk) begin
        if (rst)                    r_drop <= '0;
        else if (w_drop_sum > 9'd255) r_drop <= 8'd255;
        else                        r_drop <= w_drop_sum[7:0];
    end

    assign mq.move_valid = (r_count != '0);
    assign mq.move_dir   = r_mem[r_rptr];
    assign pending       = r_count;
    assign drop_count    = r_drop;

endmodule

// File: tb/tb_move_queue_ctrl.sv
// Bench for move_queue_ctrl: directed scenarios plus random button/ready
// traffic, checked every cycle against an event-level queue model.
module tb_move_queue_ctrl;
    import move_pkg::*;

    localparam int D     = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn;
    logic [2:0] pending;
    logic [7:0] drop_count;

    move_queue_ctrl_if mif ();

    move_queue_ctrl #(.DEBOUNCE_CYCLES(D), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .up         (btn[0]),
        .down       (btn[1]),
        .left       (btn[2]),
        .right      (btn[3]),
        .mq         (mif.master),
        .pending    (pending),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    // Model state: raw samples per edge, scheduled enqueue events, debounced levels.
    int         edge_n   = 0;
    int         last_rst = 0;
    logic [3:0] rawh [16];
    logic [3:0] evq  [16];
    logic [3:0] stable;
    logic [1:0] q [$];
    int         drop;
    int         checks = 0;
    int         passes = 0;
    int         vcount;
    int         vfirst;
    int         r_edge;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    endtask

    // A level is accepted once the synchronized input has disagreed with it on
    // D+1 consecutive post-reset edges; the move enters the queue 2 edges later.
    task automatic model_edge();
        logic [3:0] ev;
        int pre, nd, e;
        bit deq, flip, s;
        edge_n++;
        rawh[edge_n % 16] = btn;
        if (rst) begin
            q.delete();
            drop = 0;
            stable = '0;
            last_rst = edge_n;
            evq[edge_n % 16] = '0;
            evq[(edge_n + 1) % 16] = '0;
            evq[(edge_n + 2) % 16] = '0;
        end else begin
            pre = q.size();
            deq = (pre > 0) && (mif.move_ready === 1'b1);
            if (deq) void'(q.pop_front());
            ev = evq[edge_n % 16];
            evq[edge_n % 16] = '0;
            nd = 0;
            if (ev != 0) begin
                nd = $countones(ev) - 1;
                if (pre == DEPTH && !deq) nd++;
                else begin
                    for (int b = 0; b < 4; b++)
                        if (ev[b]) begin q.push_back(2'(b)); break; end
                end
            end
            drop = (drop + nd > 255) ? 255 : drop + nd;
            for (int b = 0; b < 4; b++) begin
                if (edge_n - D > last_rst) begin
                    flip = 1'b1;
                    for (int j = 0; j <= D; j++) begin
                        e = edge_n - j;
                        s = (e - 2 > last_rst) ? rawh[(e - 2) % 16][b] : 1'b0;
                        if (s == stable[b]) flip = 1'b0;
                    end
                    if (flip) begin
                        stable[b] = ~stable[b];
                        if (stable[b]) evq[(edge_n + 2) % 16][b] = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
        chk("valid", mif.move_valid, (q.size() != 0));
        chk("pending", pending, q.size());
        chk("drop", drop_count, drop);
        if (q.size() != 0) chk("dir", mif.move_dir, q[0]);
        if (mif.move_valid === 1'b1) begin
            vcount++;
            if (vfirst < 0) vfirst = edge_n;
        end
    endtask

    task automatic press(input logic [3:0] m, input int hold, input int gap);
        btn = m;
        repeat (hold) step();
        btn = '0;
        repeat (gap) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        chk("rst_dir", mif.move_dir, 0);
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin rawh[i] = '0; evq[i] = '0; end
        stable = '0;
        drop = 0;
        rst = 1'b1;
        btn = '0;
        mif.move_ready = 1'b0;
        repeat (2) step();
        chk("rst_valid", mif.move_valid, 0);
        chk("rst_pending", pending, 0);
        chk("rst_drop", drop_count, 0);
        do_reset();

        // Single left press with ready high: one-cycle valid, 8 edges after first sample.
        mif.move_ready = 1'b1;
        vcount = 0; vfirst = -1;
        r_edge = edge_n + 1;
        press(4'b0100, 20, 12);
        chk("single_pulses", vcount, 1);
        chk("single_latency", vfirst - r_edge, 8);
        chk("single_drop", drop_count, 0);

        // Short glitch on right is ignored.
        vcount = 0;
        press(4'b1000, 3, 15);
        chk("glitch_valid", vcount, 0);
        chk("glitch_pending", pending, 0);

        // Up, down, right together with ready low: up wins, two drops.
        do_reset();
        mif.move_ready = 1'b0;
        press(4'b1011, 8, 10);
        chk("simul_pending", pending, 1);
        chk("simul_dir", mif.move_dir, DIR_UP);
        chk("simul_drop", drop_count, 2);

        // Six down presses into a 4-deep queue, then drain back to back.
        do_reset();
        repeat (6) press(4'b0010, 6, 8);
        chk("ovf_pending", pending, 4);
        chk("ovf_drop", drop_count, 2);
        mif.move_ready = 1'b1;
        repeat (4) begin
            chk("drain_dir", mif.move_dir, DIR_DOWN);
            step();
        end
        chk("drain_empty", pending, 0);

        // Full queue, new up event accepted in the same cycle as a dequeue.
        do_reset();
        mif.move_ready = 1'b0;
        repeat (4) press(4'b0010, 6, 8);
        btn = 4'b0001;
        repeat (8) step();
        mif.move_ready = 1'b1;
        step();
        mif.move_ready = 1'b0;
        chk("fullacc_pending", pending, 4);
        chk("fullacc_drop", drop_count, 0);
        btn = '0;
        repeat (10) step();
        mif.move_ready = 1'b1;
        repeat (3) step();
        chk("fullacc_tail", mif.move_dir, DIR_UP);
        step();
        mif.move_ready = 1'b0;

        // Reset with three queued moves while up is held through reset.
        do_reset();
        repeat (3) press(4'b0010, 6, 8);
        chk("mid_pending", pending, 3);
        btn = 4'b0001;
        repeat (2) step();
        rst = 1'b1;
        step();
        r_edge = edge_n;
        rst = 1'b0;
        step();
        chk("mid_valid", mif.move_valid, 0);
        chk("mid_pending0", pending, 0);
        chk("mid_drop", drop_count, 0);
        vfirst = -1;
        repeat (12) step();
        chk("held_latency", vfirst - r_edge, 9);
        repeat (20) step();
        chk("held_once", pending, 1);
        btn = '0;

        // Saturation of the drop counter.
        do_reset();
        repeat (70) press(4'hF, 6, 8);
        chk("drop_sat", drop_count, 255);

        // Random buttons, ready and occasional resets.
        do_reset();
        repeat (150) begin
            if ($urandom_range(0, 39) == 0) do_reset();
            btn = ($urandom_range(0, 2) == 0) ? 4'b0 : 4'($urandom);
            repeat ($urandom_range(1, 12)) begin
                mif.move_ready = 1'($urandom_range(0, 1));
                step();
            end
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
